// File: rtl/riscv_dmacopy.sv
// riscv_dmacopy: word-copy DMA master; reads LEN words from SRC and writes each one to DST (optional DMA_TIMEOUT_EN).
// Latency: first read request the cycle after START; (rd + wr) cycles per word; DONE one cycle after the last ack.
// Backpressure: every request is held stable until XDACK; with DMA_TIMEOUT_EN an unacked request ends the run after TOUT cycles.
module riscv_dmacopy #(
    parameter int unsigned TOUT = 255
) (
    input  logic        CLK,
    input  logic        RESN,
    input  logic        START,
    input  logic        ABORT,
    input  logic [31:0] SRC,
    input  logic [31:0] DST,
    input  logic [15:0] LEN,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic        ABT,
    output logic        XDREQ,
    output logic        XRD,
    output logic        XWR,
    output logic [3:0]  XBE,
    output logic [31:0] XADDR,
    output logic [31:0] XATAO,
    input  logic [31:0] XATAI,
    input  logic        XDACK,
    output logic [15:0] REMAIN,
    output logic [3:0]  DEBUG
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [31:0] r_buf;
    logic [15:0] r_remain;
    logic        r_abt;
    logic        r_abt_pend;

    logic        w_start;
    logic        w_in_xfer;
    logic        w_abort;
    logic        w_tout;

    // START only counts in IDLE, so a pulse during a run is dropped
    assign w_start   = (r_state == S_IDLE) && START;
    assign w_in_xfer = (r_state == S_RD) || (r_state == S_WR);
    // an abort raised in the same cycle as the ack takes effect on that ack
    assign w_abort   = r_abt_pend || ABORT;

`ifdef DMA_TIMEOUT_EN
    localparam logic [7:0] TOUT_LAST = 8'(TOUT - 1);

    logic [7:0] r_tcnt;
    logic       r_err;

    // unacked-cycle counter; an ack or leaving RD/WR restarts it, so each transaction gets a fresh budget
    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            r_tcnt <= 8'd0;
        end else if (w_in_xfer && !XDACK) begin
            r_tcnt <= r_tcnt + 8'd1;
        end else begin
            r_tcnt <= 8'd0;
        end
    end

    // the request has been held TOUT cycles when this cycle also goes unacked
    assign w_tout = w_in_xfer && !XDACK && (r_tcnt == TOUT_LAST);

    // sticky timeout flag, cleared only by the next accepted START
    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            r_err <= 1'b0;
        end else if (w_start) begin
            r_err <= 1'b0;
        end else if (w_tout) begin
            r_err <= 1'b1;
        end
    end

    assign ERR = r_err;
`else
    // without the timeout counter TOUT has no effect and the block waits forever for XDACK
    assign w_tout = 1'b0 && (TOUT != 0);
    assign ERR    = 1'b0;
`endif

    // sequencer: one read then one write per word, leaving early to FIN on abort or timeout
    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            r_state    <= S_IDLE;
            r_src      <= 32'd0;
            r_dst      <= 32'd0;
            r_buf      <= 32'd0;
            r_remain   <= 16'd0;
            r_abt      <= 1'b0;
            r_abt_pend <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_abt      <= 1'b0;
                        r_abt_pend <= 1'b0;
                        if (LEN != 16'd0) begin
                            r_src    <= {SRC[31:2], 2'b00};
                            r_dst    <= {DST[31:2], 2'b00};
                            r_remain <= LEN;
                            r_state  <= S_RD;
                        end else begin
                            r_state  <= S_FIN;
                        end
                    end
                end
                S_RD: begin
                    if (ABORT) begin
                        r_abt_pend <= 1'b1;
                    end
                    if (XDACK) begin
                        r_buf <= XATAI;
                        if (w_abort) begin
                            r_abt   <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_state <= S_WR;
                        end
                    end else if (w_tout) begin
                        r_state <= S_FIN;
                    end
                end
                S_WR: begin
                    if (ABORT) begin
                        r_abt_pend <= 1'b1;
                    end
                    if (XDACK) begin
                        r_src    <= r_src + 32'd4;
                        r_dst    <= r_dst + 32'd4;
                        r_remain <= r_remain - 16'd1;
                        if (w_abort) begin
                            r_abt   <= 1'b1;
                            r_state <= S_FIN;
                        end else if (r_remain == 16'd1) begin
                            r_state <= S_FIN;
                        end else begin
                            r_state <= S_RD;
                        end
                    end else if (w_tout) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_abt_pend <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_abt_pend <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // bus outputs decode straight from state, so reset drops the request without waiting for a clock
    assign XDREQ  = w_in_xfer;
    assign XRD    = (r_state == S_RD);
    assign XWR    = (r_state == S_WR);
    assign XBE    = XWR ? 4'hF : 4'h0;
    assign XADDR  = XRD ? r_src : (XWR ? r_dst : 32'd0);
    assign XATAO  = r_buf;
    assign BUSY   = w_in_xfer;
    assign DONE   = (r_state == S_FIN);
    assign ABT    = r_abt;
    assign REMAIN = r_remain;
    assign DEBUG  = {XDREQ, XRD, XWR, XDACK};

endmodule
